// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Lets N_REQ message sources share one UART transmitter (uart_top).
// Requests are arbitrated round-robin. The winner's CHAR_NR-byte message is
// latched and driven to the transmitter, which is then told to start with a
// one-cycle update pulse. The scheduler follows the transmitter's busy flag
// until the message has gone out and then acks the requester. A transfer can
// be cancelled with abort_i. If the transmitter never raises busy, a start
// timeout ends the transfer. Both cases clear the transmitter.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   req_i             level request per source, held until ack_o
//   msg_i             message per source; slice i = [i*CHAR_NR*8 +: CHAR_NR*8]
//   ack_o             one-cycle pulse when source i's message is fully sent
//   grant_o           one-hot, source currently being served
//   abort_i           cancel the current transfer (ignored when idle)
//   uart_char_array_o message to uart_top char_array_i
//   uart_update_o     start pulse to uart_top char_array_update_i
//   uart_clr_o        clear pulse to uart_top clr_i
//   uart_busy_i       busy flag from uart_top busy_o
//   err_o             sticky start-timeout flag
//   err_clr_i         clears err_o (a same-cycle timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int CHAR_NR  = 8,
  parameter int START_TO = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*CHAR_NR*8-1:0] msg_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [N_REQ-1:0]           grant_o,
  input  logic                       abort_i,
  output logic [CHAR_NR*8-1:0]       uart_char_array_o,
  output logic                       uart_update_o,
  output logic                       uart_clr_o,
  input  logic                       uart_busy_i,
  output logic                       err_o,
  input  logic                       err_clr_i
);

  localparam int MSG_W = CHAR_NR * 8;
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(START_TO + 1);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [MSG_W-1:0]   char_q, char_d;
  logic               upd_q, upd_d;
  logic               clr_q, clr_d;
  logic               err_q, err_d;

  // Round-robin pick: the first requester after the last-served one, wrapping.
  logic               found;
  logic [PTR_W-1:0]   pick;

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req_i[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    char_d  = char_q;
    upd_d   = 1'b0;
    clr_d   = 1'b0;
    err_d   = err_q;

    if (err_clr_i) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort_i is ignored here, so a request that arrives with it still wins.
        if (found) begin
          win_d        = pick;
          grant_d      = '0;
          grant_d[pick] = 1'b1;
          char_d       = msg_i[int'(pick)*MSG_W +: MSG_W];
          upd_d        = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (abort_i) begin
          clr_d   = 1'b1;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else if (uart_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          // Transmitter never started: flag it, clear it and release the source.
          err_d   = 1'b1;
          clr_d   = 1'b1;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        // Abort beats a completion in the same cycle: the source gets no ack.
        if (abort_i) begin
          clr_d   = 1'b1;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else if (!uart_busy_i) begin
          ack_d[win_q] = 1'b1;
          grant_d      = '0;
          last_d       = win_q;
          state_d      = IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= PTR_RST;
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      char_q  <= '0;
      upd_q   <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      char_q  <= char_d;
      upd_q   <= upd_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

  assign ack_o             = ack_q;
  assign grant_o           = grant_q;
  assign uart_char_array_o = char_q;
  assign uart_update_o     = upd_q;
  assign uart_clr_o        = clr_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler (N_REQ=4, CHAR_NR=8, START_TO=16).
// The bench drives the transmitter busy flag by hand in place of uart_top.
// Inputs change 1 ns after each rising edge. Outputs are sampled at the same
// point.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [255:0] msg;
  logic [3:0]   ack;
  logic [3:0]   grant;
  logic         abort;
  logic [63:0]  chars;
  logic         update;
  logic         clr;
  logic         busy;
  logic         err;
  logic         err_clr;

  logic [63:0]  msgs [4];

  int errs   = 0;
  int checks = 0;

  uart_tx_scheduler #(
    .N_REQ   (4),
    .CHAR_NR (8),
    .START_TO(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_i            (req),
    .msg_i            (msg),
    .ack_o            (ack),
    .grant_o          (grant),
    .abort_i          (abort),
    .uart_char_array_o(chars),
    .uart_update_o    (update),
    .uart_clr_o       (clr),
    .uart_busy_i      (busy),
    .err_o            (err),
    .err_clr_i        (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = 4'b0000;
    abort   = 1'b0;
    busy    = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req     = 4'b0000;
    abort   = 1'b0;
    busy    = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    tick();
    checks++; if (ack !== 4'b0000) begin errs++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (chars !== 64'h0) begin errs++; $display("FAIL reset_chars got %h want 0", chars); end
    checks++; if (update !== 1'b0) begin errs++; $display("FAIL reset_update got %b want 0", update); end
    checks++; if (clr !== 1'b0) begin errs++; $display("FAIL reset_clr got %b want 0", clr); end
    checks++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errs++; $display("FAIL single_grant got %b want 0001", grant); end
    checks++; if (update !== 1'b1) begin errs++; $display("FAIL single_update got %b want 1", update); end
    checks++; if (chars !== 64'h3837363534333231) begin errs++; $display("FAIL single_chars got %h want 3837363534333231", chars); end
    busy = 1'b1;
    tick();
    checks++; if (update !== 1'b0) begin errs++; $display("FAIL single_update_pulse got %b want 0", update); end
    tick();
    tick();
    checks++; if (ack !== 4'b0000) begin errs++; $display("FAIL single_ack_early got %b want 0000", ack); end
    busy = 1'b0;
    tick();
    checks++; if (ack !== 4'b0001) begin errs++; $display("FAIL single_ack got %b want 0001", ack); end
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL single_grant_drop got %b want 0000", grant); end
    req = 4'b0000;
    tick();
    checks++; if (ack !== 4'b0000) begin errs++; $display("FAIL single_ack_once got %b want 0000", ack); end
    checks++; if (chars !== 64'h3837363534333231) begin errs++; $display("FAIL single_chars_hold got %h want 3837363534333231", chars); end
  endtask

  task automatic test_round_robin();
    int         order [5];
    logic [3:0] eg;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << order[i];
      tick();
      checks++; if (grant !== eg) begin errs++; $display("FAIL rr_grant[%0d] got %b want %b", i, grant, eg); end
      checks++; if (chars !== msgs[order[i]]) begin errs++; $display("FAIL rr_chars[%0d] got %h want %h", i, chars, msgs[order[i]]); end
      checks++; if (update !== 1'b1) begin errs++; $display("FAIL rr_update[%0d] got %b want 1", i, update); end
      busy = 1'b1;
      tick();
      checks++; if ($countones(grant) !== 1) begin errs++; $display("FAIL rr_onehot[%0d] got %b want one-hot", i, grant); end
      tick();
      busy = 1'b0;
      tick();
      checks++; if (ack !== eg) begin errs++; $display("FAIL rr_ack[%0d] got %b want %b", i, ack, eg); end
      if (i == 4) req = 4'b0000;
    end
    tick();
    checks++; if ({ack, grant} !== 8'h00) begin errs++; $display("FAIL rr_end got ack=%b grant=%b want 0000/0000", ack, grant); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      err_clr = (r == 1);
      req     = 4'b0001;
      busy    = 1'b0;
      tick();
      checks++; if ({grant, update} !== 5'b00011) begin errs++; $display("FAIL to_start[%0d] got grant=%b upd=%b want 0001/1", r, grant, update); end
      req = 4'b0000;
      for (int k = 1; k <= 15; k++) begin
        tick();
        checks++; if ({clr, grant} !== 5'b00001) begin errs++; $display("FAIL to_wait[%0d,%0d] got clr=%b grant=%b want 0/0001", r, k, clr, grant); end
      end
      tick();
      checks++; if (clr !== 1'b1) begin errs++; $display("FAIL to_clr[%0d] got %b want 1", r, clr); end
      checks++; if (err !== 1'b1) begin errs++; $display("FAIL to_err[%0d] got %b want 1", r, err); end
      checks++; if ({ack, grant} !== 8'h00) begin errs++; $display("FAIL to_noack[%0d] got ack=%b grant=%b want 0000/0000", r, ack, grant); end
      if (r == 0) begin
        tick();
        checks++; if ({clr, err} !== 2'b01) begin errs++; $display("FAIL to_sticky got clr=%b err=%b want 0/1", clr, err); end
        err_clr = 1'b1;
      end
      tick();
      checks++; if (err !== 1'b0) begin errs++; $display("FAIL to_errclr[%0d] got %b want 0", r, err); end
      err_clr = 1'b0;
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b1100;
    tick();
    checks++; if (grant !== 4'b0100) begin errs++; $display("FAIL ab_grant got %b want 0100", grant); end
    checks++; if (chars !== msgs[2]) begin errs++; $display("FAIL ab_chars got %h want %h", chars, msgs[2]); end
    busy = 1'b1;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    checks++; if (clr !== 1'b1) begin errs++; $display("FAIL ab_clr got %b want 1", clr); end
    checks++; if ({ack, grant} !== 8'h00) begin errs++; $display("FAIL ab_noack got ack=%b grant=%b want 0000/0000", ack, grant); end
    abort = 1'b0;
    busy  = 1'b0;
    tick();
    checks++; if (grant !== 4'b1000) begin errs++; $display("FAIL ab_next_grant got %b want 1000", grant); end
    checks++; if ({clr, update, ack} !== 6'b010000) begin errs++; $display("FAIL ab_next_ctl got clr=%b upd=%b ack=%b want 0/1/0000", clr, update, ack); end
    req  = 4'b1000;
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    checks++; if (ack !== 4'b1000) begin errs++; $display("FAIL ab_next_ack got %b want 1000", ack); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_abort_idle();
    // last-served is source 3, so source 0 is first in line.
    abort = 1'b1;
    req   = 4'b0001;
    tick();
    checks++; if ({grant, clr} !== 5'b00010) begin errs++; $display("FAIL abi_grant got grant=%b clr=%b want 0001/0", grant, clr); end
    req = 4'b0000;
    tick();
    checks++; if ({grant, clr} !== 5'b00001) begin errs++; $display("FAIL abi_wb_abort got grant=%b clr=%b want 0000/1", grant, clr); end
    abort = 1'b0;
    tick();
    checks++; if ({clr, ack} !== 5'b00000) begin errs++; $display("FAIL abi_after got clr=%b ack=%b want 0/0000", clr, ack); end
  endtask

  task automatic test_abort_completion();
    req = 4'b0010;
    tick();
    checks++; if (grant !== 4'b0010) begin errs++; $display("FAIL abc_grant got %b want 0010", grant); end
    busy = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    busy  = 1'b0;
    tick();
    checks++; if (ack !== 4'b0000) begin errs++; $display("FAIL abc_noack got %b want 0000", ack); end
    checks++; if ({clr, grant, err} !== 6'b100000) begin errs++; $display("FAIL abc_clr got clr=%b grant=%b err=%b want 1/0000/0", clr, grant, err); end
    abort = 1'b0;
    req   = 4'b0000;
    tick();
    checks++; if ({ack, grant, clr} !== 9'h000) begin errs++; $display("FAIL abc_idle got ack=%b grant=%b clr=%b want 0", ack, grant, clr); end
  endtask

  task automatic test_reset_mid();
    req = 4'b1001;
    tick();
    busy = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ack, grant} !== 8'h00) begin errs++; $display("FAIL rm_async got ack=%b grant=%b want 0000/0000", ack, grant); end
    checks++; if ({chars, update, clr, err} !== 67'h0) begin errs++; $display("FAIL rm_async_data got chars=%h upd=%b clr=%b err=%b want 0", chars, update, clr, err); end
    rst_n = 1'b1;
    busy  = 1'b0;
    tick();
    checks++; if (grant !== 4'b0001) begin errs++; $display("FAIL rm_first got %b want 0001", grant); end
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    checks++; if (ack !== 4'b0001) begin errs++; $display("FAIL rm_ack0 got %b want 0001", ack); end
    tick();
    checks++; if (grant !== 4'b1000) begin errs++; $display("FAIL rm_second got %b want 1000", grant); end
    req  = 4'b0000;
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    checks++; if (ack !== 4'b1000) begin errs++; $display("FAIL rm_ack3 got %b want 1000", ack); end
    tick();
  endtask

  initial begin
    msgs[0] = 64'h3837363534333231;
    msgs[1] = 64'hA1A2A3A4A5A6A7A8;
    msgs[2] = 64'hB1B2B3B4B5B6B7B8;
    msgs[3] = 64'hC1C2C3C4C5C6C7C8;
    msg     = {msgs[3], msgs[2], msgs[1], msgs[0]};

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_abort();
    test_abort_idle();
    test_abort_completion();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
